muldiv_stim_gen: RTL and testbench

Upstream stimulus sequencer for the MulDiv unit in the power-evaluation top. It generates a bounded stream of pseudo-random multiply/divide requests over the MulDiv request handshake and optionally kills selected requests. It consumes every response, checks its tag and folds its data into a 32-bit signature. Switching-activity runs and the regression bench both drive the MulDiv instance through this block.

---
 rtl/muldiv_stim_gen.sv | 207 ++++++++++++++++++++
 tb/tb_muldiv_stim_gen.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_stim_gen.sv
// Pseudo-random request sequencer for the MulDiv unit: issues one request at a time,
// optionally kills it, checks response tags and folds response data into a signature.
module muldiv_stim_gen #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] num_ops,
  input  logic [31:0] seed,
  input  logic [7:0]  kill_every,
  input  logic        cfg_dw,
  input  logic        io_req_ready,
  output logic        io_req_valid,
  output logic [3:0]  io_req_bits_fn,
  output logic        io_req_bits_dw,
  output logic [31:0] io_req_bits_in1,
  output logic [31:0] io_req_bits_in2,
  output logic [4:0]  io_req_bits_tag,
  output logic        io_kill,
  output logic        io_resp_ready,
  input  logic        io_resp_valid,
  input  logic [31:0] io_resp_bits_data,
  input  logic [4:0]  io_resp_bits_tag,
  output logic        busy,
  output logic        done,
  output logic        tag_error,
  output logic        timeout_error,
  output logic [15:0] ops_done,
  output logic [15:0] ops_killed,
  output logic [31:0] signature
);

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] SEED2_MIX = 32'h9E37_79B9;
  localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 32'd1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_KILL  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_num_ops;
  logic [15:0] r_issued;
  logic [15:0] r_ops_done;
  logic [15:0] r_ops_killed;
  logic [31:0] r_lfsr1;
  logic [31:0] r_lfsr2;
  logic [31:0] r_signature;
  logic        r_tag_error;
  logic        r_timeout_error;
  logic [7:0]  r_wait_cnt;

  logic        w_start_ok;
  logic        w_fire;
  logic        w_resp;
  logic        w_timeout;
  logic        w_more;
  logic        w_kill_hit;
  logic [15:0] w_issued_nxt;
  logic [4:0]  w_exp_tag;
  logic [31:0] w_init_l1;
  logic [31:0] w_init_l2_raw;
  logic [31:0] w_init_l2;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_TAPS : 32'h0000_0000);
  endfunction

  // A zero LFSR would lock up, so both seeds are forced non-zero.
  assign w_init_l1     = (seed == 32'h0000_0000) ? 32'h0000_0001 : seed;
  assign w_init_l2_raw = w_init_l1 ^ SEED2_MIX;
  assign w_init_l2     = (w_init_l2_raw == 32'h0000_0000) ? 32'h0000_0001 : w_init_l2_raw;

  assign w_start_ok   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_fire       = (r_state == ST_ISSUE) && io_req_ready;
  assign w_resp       = (r_state == ST_WAIT) && io_resp_valid;
  assign w_timeout    = (r_state == ST_WAIT) && !io_resp_valid && (r_wait_cnt == WAIT_LAST);
  assign w_more       = (r_issued < r_num_ops);
  assign w_issued_nxt = r_issued + 16'd1;
  assign w_exp_tag    = r_issued[4:0] - 5'd1;
  assign w_kill_hit   = (kill_every != 8'd0) &&
                        ((w_issued_nxt % {8'd0, kill_every}) == 16'd0);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = (num_ops != 16'd0) ? ST_ISSUE : ST_DONE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_ISSUE: begin
        if (io_req_ready) begin
          w_state_nxt = w_kill_hit ? ST_KILL : ST_WAIT;
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_KILL: begin
        w_state_nxt = w_more ? ST_ISSUE : ST_DONE;
      end
      ST_WAIT: begin
        if (io_resp_valid) begin
          w_state_nxt = w_more ? ST_ISSUE : ST_DONE;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Run length, issue index and operand LFSRs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_num_ops <= 16'd0;
      r_issued  <= 16'd0;
      r_lfsr1   <= 32'h0000_0000;
      r_lfsr2   <= 32'h0000_0000;
    end else if (w_start_ok) begin
      r_num_ops <= num_ops;
      r_issued  <= 16'd0;
      r_lfsr1   <= w_init_l1;
      r_lfsr2   <= w_init_l2;
    end else if (w_fire) begin
      r_issued  <= w_issued_nxt;
      r_lfsr1   <= lfsr_step(r_lfsr1);
      r_lfsr2   <= lfsr_step(r_lfsr2);
    end
  end

  // Result counters, sticky error flags and response signature
  always_ff @(posedge clock) begin
    if (reset || w_start_ok) begin
      r_ops_done      <= 16'd0;
      r_ops_killed    <= 16'd0;
      r_signature     <= 32'h0000_0000;
      r_tag_error     <= 1'b0;
      r_timeout_error <= 1'b0;
    end else begin
      if (r_state == ST_KILL) begin
        r_ops_killed <= r_ops_killed + 16'd1;
      end
      if (w_resp) begin
        if (io_resp_bits_tag != w_exp_tag) begin
          r_tag_error <= 1'b1;
        end
        r_signature <= {r_signature[30:0], r_signature[31]} ^ io_resp_bits_data;
        r_ops_done  <= r_ops_done + 16'd1;
      end
      if (w_timeout) begin
        r_timeout_error <= 1'b1;
      end
    end
  end

  // Watchdog: restarts from zero on every entry into WAIT
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wait_cnt <= 8'd0;
    end else if (r_state == ST_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end else begin
      r_wait_cnt <= 8'd0;
    end
  end

  assign io_req_valid    = (r_state == ST_ISSUE);
  assign io_kill         = (r_state == ST_KILL);
  assign io_resp_ready   = (r_state == ST_WAIT);
  assign busy            = (r_state == ST_ISSUE) || (r_state == ST_KILL) || (r_state == ST_WAIT);
  assign done            = (r_state == ST_DONE);
  assign io_req_bits_fn  = {1'b0, r_issued[2:0]};
  assign io_req_bits_tag = r_issued[4:0];
  assign io_req_bits_dw  = cfg_dw;
  assign io_req_bits_in1 = r_lfsr1;
  assign io_req_bits_in2 = r_lfsr2;
  assign tag_error       = r_tag_error;
  assign timeout_error   = r_timeout_error;
  assign ops_done        = r_ops_done;
  assign ops_killed      = r_ops_killed;
  assign signature       = r_signature;

endmodule

// File: tb/tb_muldiv_stim_gen.sv
// Self-checking bench for muldiv_stim_gen: a behavioural MulDiv responder plus a
// reference model of the expected request stream, kill pattern and signature.
module tb_muldiv_stim_gen;

  logic        clock = 1'b0;
  logic        reset, start, cfg_dw, io_req_ready, io_resp_valid;
  logic [15:0] num_ops;
  logic [31:0] seed, io_resp_bits_data;
  logic [7:0]  kill_every;
  logic [4:0]  io_resp_bits_tag;
  logic        io_req_valid, io_req_bits_dw, io_kill, io_resp_ready;
  logic        busy, done, tag_error, timeout_error;
  logic [3:0]  io_req_bits_fn;
  logic [31:0] io_req_bits_in1, io_req_bits_in2, signature;
  logic [4:0]  io_req_bits_tag;
  logic [15:0] ops_done, ops_killed;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] q_in1[$], q_in2[$], q_rsp[$];
  logic [3:0]  q_fn[$];
  logic [4:0]  q_tag[$];
  logic        q_dw[$], q_kill[$];
  logic        hung;
  int          wait_cycles, valid_cycles, n_unstable;

  always #5 clock = ~clock;

  muldiv_stim_gen #(.TIMEOUT(10)) dut (
    .clock(clock), .reset(reset), .start(start), .num_ops(num_ops), .seed(seed),
    .kill_every(kill_every), .cfg_dw(cfg_dw), .io_req_ready(io_req_ready),
    .io_req_valid(io_req_valid), .io_req_bits_fn(io_req_bits_fn),
    .io_req_bits_dw(io_req_bits_dw), .io_req_bits_in1(io_req_bits_in1),
    .io_req_bits_in2(io_req_bits_in2), .io_req_bits_tag(io_req_bits_tag),
    .io_kill(io_kill), .io_resp_ready(io_resp_ready), .io_resp_valid(io_resp_valid),
    .io_resp_bits_data(io_resp_bits_data), .io_resp_bits_tag(io_resp_bits_tag),
    .busy(busy), .done(done), .tag_error(tag_error), .timeout_error(timeout_error),
    .ops_done(ops_done), .ops_killed(ops_killed), .signature(signature)
  );

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return l[0] ? ((l / 32'd2) ^ 32'h80200003) : (l / 32'd2);
  endfunction

  function automatic logic [31:0] sig_model();
    logic [31:0] s = 32'h0;
    foreach (q_rsp[i]) s = ((s << 1) | (s >> 31)) ^ q_rsp[i];
    return s;
  endfunction

  task automatic start_run(input logic [15:0] n, input logic [31:0] sd,
                           input logic [7:0] ke, input logic dw);
    num_ops = n; seed = sd; kill_every = ke; cfg_dw = dw; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Ideal MulDiv: accepts with probability rdy_pct, answers non-killed ops after lat WAIT cycles.
  task automatic run_dut(input int lat, input int rdy_pct, input int bad_op,
                         input logic [4:0] bad_tag, input logic [31:0] bad_data,
                         input logic spur, input int budget);
    logic prev_fire = 1'b0, live = 1'b0, held = 1'b0;
    logic [4:0]  ptag = 5'd0;
    logic [31:0] d, h1 = 32'h0, h2 = 32'h0;
    int lcnt = 0, cyc = 0;
    q_in1.delete(); q_in2.delete(); q_fn.delete(); q_tag.delete();
    q_dw.delete(); q_kill.delete(); q_rsp.delete();
    hung = 1'b0; wait_cycles = 0; valid_cycles = 0; n_unstable = 0;
    forever begin
      io_req_ready = 1'b0; io_resp_valid = 1'b0;
      io_resp_bits_data = 32'h0; io_resp_bits_tag = 5'd0;
      if (prev_fire) begin
        q_kill.push_back(io_kill);
        if (!io_kill) begin live = 1'b1; lcnt = lat; end
        else if (spur) begin
          io_resp_valid = 1'b1; io_resp_bits_data = 32'hDEADBEEF; io_resp_bits_tag = ptag;
        end
      end
      prev_fire = 1'b0;
      if (done) break;
      if (cyc >= budget) begin hung = 1'b1; break; end
      if (io_resp_ready) wait_cycles++;
      if (io_req_valid) begin
        valid_cycles++;
        if (held && (io_req_bits_in1 !== h1 || io_req_bits_in2 !== h2)) n_unstable++;
        held = 1'b1; h1 = io_req_bits_in1; h2 = io_req_bits_in2;
        if (int'($urandom_range(0, 99)) < rdy_pct) begin
          io_req_ready = 1'b1;
          q_in1.push_back(io_req_bits_in1); q_in2.push_back(io_req_bits_in2);
          q_fn.push_back(io_req_bits_fn);   q_tag.push_back(io_req_bits_tag);
          q_dw.push_back(io_req_bits_dw);
          ptag = io_req_bits_tag; prev_fire = 1'b1; held = 1'b0;
        end
      end else begin
        held = 1'b0;
      end
      if (live) begin
        if (lcnt > 0) lcnt--;
        else begin
          d = (q_rsp.size() == bad_op) ? bad_data : $urandom;
          io_resp_valid = 1'b1; io_resp_bits_data = d;
          io_resp_bits_tag = (q_rsp.size() == bad_op) ? bad_tag : ptag;
          if (io_resp_ready) begin q_rsp.push_back(d); live = 1'b0; end
        end
      end
      @(negedge clock);
      cyc++;
    end
    io_req_ready = 1'b0; io_resp_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++; if ({io_req_valid, io_kill, io_resp_ready, busy, done} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {io_req_valid, io_kill, io_resp_ready, busy, done}); else n_pass++;
    n_checks++; if ({ops_done, ops_killed, signature, tag_error, timeout_error} !== 66'h0)
      $display("FAIL reset_status: got %h want 0", {ops_done, ops_killed, signature, tag_error, timeout_error}); else n_pass++;
    n_checks++; if ({io_req_bits_in1, io_req_bits_in2, io_req_bits_fn, io_req_bits_tag} !== 73'h0)
      $display("FAIL reset_req: got %h want 0", {io_req_bits_in1, io_req_bits_in2, io_req_bits_fn, io_req_bits_tag}); else n_pass++;
    reset = 1'b0;
    @(negedge clock);
    n_checks++; if ({busy, done, io_req_valid} !== 3'b000)
      $display("FAIL reset_idle: got %b want 000", {busy, done, io_req_valid}); else n_pass++;
  endtask

  task automatic test_basic;
    start_run(16'd2, 32'd1, 8'd0, 1'b1);
    n_checks++; if ({io_req_valid, busy} !== 2'b11)
      $display("FAIL basic_valid_rise: got %b want 11", {io_req_valid, busy}); else n_pass++;
    run_dut(0, 100, -1, 5'd0, 32'h0, 1'b0, 200);
    n_checks++; if ({hung, q_in1.size()} !== {1'b0, 32'd2})
      $display("FAIL basic_issue_count: got hung=%0b n=%0d want hung=0 n=2", hung, q_in1.size()); else n_pass++;
    if (q_in1.size() >= 2) begin
      n_checks++; if ({q_in1[0], q_in2[0], q_fn[0], q_tag[0], q_dw[0]} !== {32'h00000001, 32'h9E3779B8, 4'd0, 5'd0, 1'b1})
        $display("FAIL basic_req0: got %h %h fn=%0d tag=%0d dw=%0b want 00000001 9e3779b8 fn=0 tag=0 dw=1",
                 q_in1[0], q_in2[0], q_fn[0], q_tag[0], q_dw[0]); else n_pass++;
      n_checks++; if ({q_in1[1], q_in2[1], q_fn[1], q_tag[1]} !== {32'h80200003, 32'h4F1BBCDC, 4'd1, 5'd1})
        $display("FAIL basic_req1: got %h %h fn=%0d tag=%0d want 80200003 4f1bbcdc fn=1 tag=1",
                 q_in1[1], q_in2[1], q_fn[1], q_tag[1]); else n_pass++;
    end
    n_checks++; if ({done, ops_done, ops_killed, tag_error, timeout_error} !== {1'b1, 16'd2, 16'd0, 2'b00})
      $display("FAIL basic_end: got done=%0b done_ops=%0d killed=%0d te=%0b to=%0b want 1 2 0 0 0",
               done, ops_done, ops_killed, tag_error, timeout_error); else n_pass++;
    n_checks++; if (signature !== sig_model())
      $display("FAIL basic_sig: got %h want %h", signature, sig_model()); else n_pass++;
  endtask

  task automatic test_zero_ops;
    int vcnt = 0;
    start_run(16'd0, 32'h1234, 8'd0, 1'b0);
    n_checks++; if ({done, busy} !== 2'b10)
      $display("FAIL zero_done: got done=%0b busy=%0b want 1 0", done, busy); else n_pass++;
    repeat (4) begin
      vcnt += int'(io_req_valid);
      @(negedge clock);
    end
    n_checks++; if ({vcnt, ops_done, done} !== {32'd0, 16'd0, 1'b1})
      $display("FAIL zero_quiet: got valids=%0d ops_done=%0d done=%0b want 0 0 1", vcnt, ops_done, done); else n_pass++;
  endtask

  task automatic test_kill;
    start_run(16'd4, $urandom, 8'd2, 1'b0);
    run_dut(1, 100, -1, 5'd0, 32'h0, 1'b1, 300);
    n_checks++; if ({hung, q_kill.size(), q_rsp.size()} !== {1'b0, 32'd4, 32'd2})
      $display("FAIL kill_counts: got hung=%0b fires=%0d resps=%0d want 0 4 2", hung, q_kill.size(), q_rsp.size()); else n_pass++;
    if (q_kill.size() == 4) begin
      n_checks++; if ({q_kill[0], q_kill[1], q_kill[2], q_kill[3]} !== 4'b0101)
        $display("FAIL kill_pattern: got %b want 0101", {q_kill[0], q_kill[1], q_kill[2], q_kill[3]}); else n_pass++;
      n_checks++; if ({q_tag[0], q_tag[1], q_tag[2], q_tag[3]} !== {5'd0, 5'd1, 5'd2, 5'd3})
        $display("FAIL kill_tags: got %0d %0d %0d %0d want 0 1 2 3", q_tag[0], q_tag[1], q_tag[2], q_tag[3]); else n_pass++;
    end
    n_checks++; if ({done, ops_killed, ops_done, tag_error} !== {1'b1, 16'd2, 16'd2, 1'b0})
      $display("FAIL kill_end: got done=%0b killed=%0d ops_done=%0d te=%0b want 1 2 2 0", done, ops_killed, ops_done, tag_error); else n_pass++;
    n_checks++; if (signature !== sig_model())
      $display("FAIL kill_sig: got %h want %h", signature, sig_model()); else n_pass++;
  endtask

  task automatic test_tag_error;
    start_run(16'd1, $urandom, 8'd0, 1'b0);
    run_dut(2, 100, 0, 5'd7, 32'h12345678, 1'b0, 200);
    n_checks++; if ({hung, done, tag_error, ops_done, signature} !== {3'b011, 16'd1, 32'h12345678})
      $display("FAIL tagerr_single: got hung=%0b done=%0b te=%0b ops=%0d sig=%h want 0 1 1 1 12345678",
               hung, done, tag_error, ops_done, signature); else n_pass++;
    start_run(16'd3, $urandom, 8'd0, 1'b0);
    run_dut(1, 100, 2, 5'd0, 32'hCAFEF00D, 1'b0, 200);
    n_checks++; if ({hung, done, tag_error, timeout_error, ops_done} !== {4'b0110, 16'd3})
      $display("FAIL tagerr_continue: got hung=%0b done=%0b te=%0b to=%0b ops=%0d want 0 1 1 0 3",
               hung, done, tag_error, timeout_error, ops_done); else n_pass++;
    n_checks++; if (signature !== sig_model())
      $display("FAIL tagerr_sig: got %h want %h", signature, sig_model()); else n_pass++;
  endtask

  task automatic test_timeout;
    start_run(16'd3, $urandom, 8'd0, 1'b0);
    run_dut(1000, 100, -1, 5'd0, 32'h0, 1'b0, 200);
    n_checks++; if ({hung, wait_cycles, q_in1.size()} !== {1'b0, 32'd10, 32'd1})
      $display("FAIL timeout_cycles: got hung=%0b wait=%0d issued=%0d want 0 10 1", hung, wait_cycles, q_in1.size()); else n_pass++;
    n_checks++; if ({done, timeout_error, tag_error, ops_done} !== {3'b110, 16'd0})
      $display("FAIL timeout_flags: got done=%0b to=%0b te=%0b ops=%0d want 1 1 0 0", done, timeout_error, tag_error, ops_done); else n_pass++;
    start_run(16'd1, $urandom, 8'd0, 1'b0);
    run_dut(9, 100, -1, 5'd0, 32'h0, 1'b0, 200);
    n_checks++; if ({hung, done, timeout_error, ops_done, wait_cycles} !== {3'b010, 16'd1, 32'd10})
      $display("FAIL timeout_resp_wins: got hung=%0b done=%0b to=%0b ops=%0d wait=%0d want 0 1 0 1 10",
               hung, done, timeout_error, ops_done, wait_cycles); else n_pass++;
  endtask

  task automatic test_random;
    for (int it = 0; it < 8; it++) begin
      logic [31:0] sd, e1, e2;
      int n, ke, kills;
      logic dw, ekill;
      sd = (it == 0) ? 32'h0 : (it == 1) ? 32'h9E3779B9 : $urandom;
      n  = (it == 3) ? 40 : int'($urandom_range(1, 20));
      ke = int'($urandom_range(0, 5));
      dw = 1'($urandom_range(0, 1));
      start_run(16'(n), sd, 8'(ke), dw);
      run_dut(int'($urandom_range(0, 8)), int'($urandom_range(30, 100)), -1, 5'd0, 32'h0, 1'b0, 3000);
      n_checks++; if ({hung, q_in1.size(), q_kill.size(), n_unstable} !== {1'b0, n, n, 32'd0})
        $display("FAIL rand%0d_shape: got hung=%0b fires=%0d kills=%0d unstable=%0d want 0 %0d %0d 0",
                 it, hung, q_in1.size(), q_kill.size(), n_unstable, n, n); else n_pass++;
      e1 = (sd == 32'h0) ? 32'h1 : sd;
      e2 = e1 ^ 32'h9E3779B9;
      if (e2 == 32'h0) e2 = 32'h1;
      kills = 0;
      for (int k = 0; k < n; k++) begin
        ekill = (ke != 0) && (((k + 1) % ke) == 0);
        kills += int'(ekill);
        if (k < q_in1.size() && k < q_kill.size()) begin
          n_checks++; if ({q_in1[k], q_in2[k], q_fn[k], q_tag[k], q_dw[k], q_kill[k]} !== {e1, e2, {1'b0, 3'(k)}, 5'(k), dw, ekill})
            $display("FAIL rand%0d_op%0d: got %h %h fn=%0d tag=%0d dw=%0b kill=%0b want %h %h fn=%0d tag=%0d dw=%0b kill=%0b",
                     it, k, q_in1[k], q_in2[k], q_fn[k], q_tag[k], q_dw[k], q_kill[k],
                     e1, e2, k % 8, k % 32, dw, ekill); else n_pass++;
        end
        e1 = lfsr_next(e1);
        e2 = lfsr_next(e2);
      end
      n_checks++; if ({done, ops_done, ops_killed, tag_error, timeout_error} !== {1'b1, 16'(n - kills), 16'(kills), 2'b00})
        $display("FAIL rand%0d_end: got done=%0b ops=%0d killed=%0d te=%0b to=%0b want 1 %0d %0d 0 0",
                 it, done, ops_done, ops_killed, tag_error, timeout_error, n - kills, kills); else n_pass++;
      n_checks++; if (signature !== sig_model())
        $display("FAIL rand%0d_sig: got %h want %h", it, signature, sig_model()); else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    start_run(16'd3, 32'd5, 8'd0, 1'b0);
    io_req_ready = 1'b1; @(negedge clock); io_req_ready = 1'b0;
    io_resp_valid = 1'b1; io_resp_bits_tag = 5'd9; io_resp_bits_data = 32'hA5A5A5A5;
    @(negedge clock); io_resp_valid = 1'b0;
    io_req_ready = 1'b1; @(negedge clock); io_req_ready = 1'b0;
    @(negedge clock);
    n_checks++; if ({io_resp_ready, tag_error, ops_done, signature} !== {2'b11, 16'd1, 32'hA5A5A5A5})
      $display("FAIL rstmid_pre: got rr=%0b te=%0b ops=%0d sig=%h want 1 1 1 a5a5a5a5",
               io_resp_ready, tag_error, ops_done, signature); else n_pass++;
    reset = 1'b1;
    @(negedge clock);
    n_checks++; if ({io_kill, io_req_valid, io_resp_ready, busy, done, tag_error, ops_done, signature, io_req_bits_in1} !== 86'h0)
      $display("FAIL rstmid_cleared: got kill=%0b v=%0b rr=%0b busy=%0b done=%0b te=%0b ops=%0d sig=%h in1=%h want all 0",
               io_kill, io_req_valid, io_resp_ready, busy, done, tag_error, ops_done, signature, io_req_bits_in1); else n_pass++;
    reset = 1'b0;
    start_run(16'd1, 32'd1, 8'd0, 1'b0);
    run_dut(0, 100, -1, 5'd0, 32'h0, 1'b0, 200);
    n_checks++; if ({hung, q_in1.size()} !== {1'b0, 32'd1})
      $display("FAIL rstmid_fires: got hung=%0b n=%0d want 0 1", hung, q_in1.size()); else n_pass++;
    if (q_in1.size() >= 1) begin
      n_checks++; if ({q_in1[0], q_tag[0]} !== {32'h00000001, 5'd0})
        $display("FAIL rstmid_req0: got in1=%h tag=%0d want 00000001 0", q_in1[0], q_tag[0]); else n_pass++;
    end
    n_checks++; if ({done, tag_error, timeout_error, ops_done} !== {3'b100, 16'd1})
      $display("FAIL rstmid_end: got done=%0b te=%0b to=%0b ops=%0d want 1 0 0 1", done, tag_error, timeout_error, ops_done); else n_pass++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_ops = 16'd0; seed = 32'h0; kill_every = 8'd0;
    cfg_dw = 1'b0; io_req_ready = 1'b0; io_resp_valid = 1'b0;
    io_resp_bits_data = 32'h0; io_resp_bits_tag = 5'd0;
    @(negedge clock);
    test_reset();
    test_basic();
    test_zero_ops();
    test_kill();
    test_tag_error();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
